stall_ctrl: RTL and testbench



---
 rtl/stall_ctrl_pkg.sv | 33 +++
 rtl/stall_ctrl.sv | 148 ++++++++++++++
 tb/tb_stall_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared stall-bus definitions for the pipeline hazard controller:
// bus width, stage bit indices, enable constants, FSM and stall-cause encodings.
package stall_ctrl_pkg;

    localparam int unsigned STALL_W   = 5;

    localparam int unsigned STALL_IF  = 0;
    localparam int unsigned STALL_ID  = 1;
    localparam int unsigned STALL_EX  = 2;
    localparam int unsigned STALL_MEM = 3;
    localparam int unsigned STALL_WB  = 4;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int unsigned PC_W = 32;

    // KILL means a fetch issued before a redirect is still outstanding.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } stall_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_RST,
        CAUSE_MEM,
        CAUSE_JUMP,
        CAUSE_LOAD_USE,
        CAUSE_FETCH
    } stall_cause_e;

endpackage

// File: rtl/stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline; outputs are combinational
// from the RUN/KILL state and the current requests. Optional counters: STALL_PERF_EN.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned STAGE_NUM = STALL_W
`ifdef STALL_PERF_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 if_stall_req,
    input  logic                 if_fetch_done,
    input  logic                 id_stall_req,
    input  logic                 mem_stall_req,
    input  logic                 ex_jump_req,
    input  logic [PC_W-1:0]      ex_jump_target,
    output logic [STAGE_NUM-1:0] stall_ctrler,
    output logic                 jump_enable,
    output logic [PC_W-1:0]      jump_pc,
    output logic                 if_discard
`ifdef STALL_PERF_EN
    ,
    output logic [CNT_W-1:0]     perf_mem_stall,
    output logic [CNT_W-1:0]     perf_load_use,
    output logic [CNT_W-1:0]     perf_flush
`endif
);

    // Prefix mask: every stage up to and including k is held.
    function automatic logic [STAGE_NUM-1:0] hold_upto(input int unsigned k);
        logic [STAGE_NUM-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < STAGE_NUM; i++) begin
            m[i] = (i <= k);
        end
        return m;
    endfunction

    localparam logic [STAGE_NUM-1:0] HOLD_NONE = '0;
    localparam logic [STAGE_NUM-1:0] HOLD_IF   = hold_upto(STALL_IF);
    localparam logic [STAGE_NUM-1:0] HOLD_ID   = hold_upto(STALL_ID);
    localparam logic [STAGE_NUM-1:0] HOLD_MEM  = hold_upto(STALL_MEM);

    stall_state_e state_q;
    stall_state_e state_d;
    stall_cause_e cause;
    logic         kill_after_edge;

    // Winning stall cause, next state and all outputs.
    always_comb begin
        cause           = CAUSE_NONE;
        state_d         = state_q;
        kill_after_edge = 1'b0;
        stall_ctrler    = HOLD_NONE;
        jump_enable     = DISABLE;
        jump_pc         = '0;
        if_discard      = DISABLE;

        if (rst) begin
            cause = CAUSE_RST;
        end else if (mem_stall_req) begin
            cause = CAUSE_MEM;
        end else if (ex_jump_req) begin
            cause = CAUSE_JUMP;
        end else if (id_stall_req) begin
            cause = CAUSE_LOAD_USE;
        end else if (if_stall_req || (state_q == ST_KILL)) begin
            cause = CAUSE_FETCH;
        end

        if (cause == CAUSE_JUMP) begin
            jump_enable = ENABLE;
            jump_pc     = ex_jump_target;
        end

        // A redirect with a fetch still outstanding must drop that fetch's word.
        if (rst) begin
            state_d = ST_RUN;
        end else if (jump_enable && if_stall_req && !if_fetch_done) begin
            state_d = ST_KILL;
        end else if ((state_q == ST_KILL) && !if_fetch_done) begin
            state_d = ST_KILL;
        end else begin
            state_d = ST_RUN;
        end

        kill_after_edge = rdy ? (state_d == ST_KILL) : (state_q == ST_KILL);

        unique case (cause)
            CAUSE_MEM:      stall_ctrler = HOLD_MEM;
            CAUSE_JUMP:     stall_ctrler = kill_after_edge ? HOLD_IF : HOLD_NONE;
            CAUSE_LOAD_USE: stall_ctrler = HOLD_ID;
            CAUSE_FETCH:    stall_ctrler = HOLD_IF;
            default:        stall_ctrler = HOLD_NONE;
        endcase

        if (!rst) begin
            if_discard = (state_q == ST_KILL) || (jump_enable && if_fetch_done);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] mem_cnt_q,  mem_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q,   lu_cnt_d;
    logic [CNT_W-1:0] fl_cnt_q,   fl_cnt_d;

    // Wrapping per-cause event counters, frozen while rdy is low.
    always_comb begin
        mem_cnt_d = mem_cnt_q;
        lu_cnt_d  = lu_cnt_q;
        fl_cnt_d  = fl_cnt_q;
        if (rdy) begin
            if (cause == CAUSE_MEM)      mem_cnt_d = mem_cnt_q + CNT_W'(1);
            if (cause == CAUSE_LOAD_USE) lu_cnt_d  = lu_cnt_q + CNT_W'(1);
            if (cause == CAUSE_JUMP)     fl_cnt_d  = fl_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cnt_q <= '0;
            lu_cnt_q  <= '0;
            fl_cnt_q  <= '0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            lu_cnt_q  <= lu_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
        end
    end

    assign perf_mem_stall = mem_cnt_q;
    assign perf_load_use  = lu_cnt_q;
    assign perf_flush     = fl_cnt_q;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Randomized self-checking bench for stall_ctrl against a behavioural model
// (held-stage depth plus a "stale fetch outstanding" flag). Honours STALL_PERF_EN.
module tb_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        if_stall_req;
    logic        if_fetch_done;
    logic        id_stall_req;
    logic        mem_stall_req;
    logic        ex_jump_req;
    logic [31:0] ex_jump_target;
    logic [4:0]  stall_ctrler;
    logic        jump_enable;
    logic [31:0] jump_pc;
    logic        if_discard;
`ifdef STALL_PERF_EN
    logic [31:0] perf_mem_stall;
    logic [31:0] perf_load_use;
    logic [31:0] perf_flush;
`endif

    stall_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .if_stall_req   (if_stall_req),
        .if_fetch_done  (if_fetch_done),
        .id_stall_req   (id_stall_req),
        .mem_stall_req  (mem_stall_req),
        .ex_jump_req    (ex_jump_req),
        .ex_jump_target (ex_jump_target),
        .stall_ctrler   (stall_ctrler),
        .jump_enable    (jump_enable),
        .jump_pc        (jump_pc),
        .if_discard     (if_discard)
`ifdef STALL_PERF_EN
        ,
        .perf_mem_stall (perf_mem_stall),
        .perf_load_use  (perf_load_use),
        .perf_flush     (perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: a fetch issued before a redirect is still outstanding.
    bit stale_pending = 1'b0;
    int cnt_mem = 0;
    int cnt_lu  = 0;
    int cnt_fl  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic ifs, input logic ifd,
                         input logic ids, input logic mems, input logic jmp,
                         input logic [31:0] tgt);
        rst            = r;
        rdy            = rd;
        if_stall_req   = ifs;
        if_fetch_done  = ifd;
        id_stall_req   = ids;
        mem_stall_req  = mems;
        ex_jump_req    = jmp;
        ex_jump_target = tgt;
    endtask

    // Called just after a negedge: check outputs, advance one clock, end on the next negedge.
    task automatic step();
        bit jump_wins;
        bit next_pending;
        bit pending_after;
        int depth;
        logic [4:0]  exp_stall;
        logic        exp_je;
        logic [31:0] exp_pc;
        logic        exp_disc;
        #1;
        jump_wins     = !rst && !mem_stall_req && ex_jump_req;
        next_pending  = rst ? 1'b0 :
                        (jump_wins && if_stall_req && !if_fetch_done) ? 1'b1 :
                        (stale_pending && !if_fetch_done);
        pending_after = rst ? 1'b0 : (rdy ? next_pending : stale_pending);
        if (rst)                                 depth = 0;
        else if (mem_stall_req)                  depth = 4;
        else if (ex_jump_req)                    depth = pending_after ? 1 : 0;
        else if (id_stall_req)                   depth = 2;
        else if (if_stall_req || stale_pending)  depth = 1;
        else                                     depth = 0;
        exp_stall = 5'((1 << depth) - 1);
        exp_je    = jump_wins;
        exp_pc    = jump_wins ? ex_jump_target : 32'h0;
        exp_disc  = !rst && (stale_pending || (jump_wins && if_fetch_done));
        check("stall_ctrler", 32'(stall_ctrler), 32'(exp_stall));
        check("jump_enable",  32'(jump_enable),  32'(exp_je));
        check("jump_pc",      jump_pc,           exp_pc);
        check("if_discard",   32'(if_discard),   32'(exp_disc));
`ifdef STALL_PERF_EN
        check("perf_mem_stall", perf_mem_stall, 32'(cnt_mem));
        check("perf_load_use",  perf_load_use,  32'(cnt_lu));
        check("perf_flush",     perf_flush,     32'(cnt_fl));
`endif
        @(posedge clk);
        if (rst) begin
            cnt_mem = 0;
            cnt_lu  = 0;
            cnt_fl  = 0;
        end else if (rdy) begin
            if (mem_stall_req)                     cnt_mem++;
            else if (ex_jump_req)                  cnt_fl++;
            else if (id_stall_req)                 cnt_lu++;
        end
        stale_pending = pending_after;
        @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);

        // Reset with every request high
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        #1;
        check("rst_stall", 32'(stall_ctrler), 32'h0);
        check("rst_je",    32'(jump_enable),  32'h0);
        check("rst_disc",  32'(if_discard),   32'h0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // Load-use, then load-use masked by a jump
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check("lu_stall", 32'(stall_ctrler), 32'h03);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000);
        #1;
        check("lu_jump_je",    32'(jump_enable),  32'h1);
        check("lu_jump_pc",    jump_pc,           32'h1000);
        check("lu_jump_stall", 32'(stall_ctrler), 32'h0);
        step();

        // MEM wait holds back a jump
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4444);
            #1;
            check("memj_stall", 32'(stall_ctrler), 32'h0F);
            check("memj_je",    32'(jump_enable),  32'h0);
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4444);
        #1;
        check("memj_release_je", 32'(jump_enable), 32'h1);
        step();

        // Redirect with a fetch in flight
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
        #1;
        check("kill_je",    32'(jump_enable),  32'h1);
        check("kill_stall", 32'(stall_ctrler), 32'h01);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            #1;
            check("kill_disc",       32'(if_discard),   32'h1);
            check("kill_hold_stall", 32'(stall_ctrler), 32'h01);
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("kill_exit_disc", 32'(if_discard), 32'h0);
        step();

        // Jump coincident with fetch return
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
        #1;
        check("coinc_disc", 32'(if_discard), 32'h1);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("coinc_after_disc", 32'(if_discard), 32'h0);
        step();

        // rdy low freezes KILL across a fetch-done pulse
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("rdy_hold_disc", 32'(if_discard), 32'h1);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // Counter check after reset and four mem stalls
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef STALL_PERF_EN
        #1;
        check("perf_mem_4", perf_mem_stall, 32'd4);
`endif
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 39) == 0,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 1) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
